// File: rtl/ps2_host_tx.sv
// ---------------------------------------------------------------------------
// ps2_host_tx
// Host-to-device PS/2 transmitter. Sends one command byte (e.g. 0xED LED set,
// 0xFF reset) to the keyboard over the open-drain PS2_CLK / PS2_DAT pair:
// inhibit the clock, issue the request-to-send, shift out data LSB first with
// odd parity and a stop bit, then sample the device's ACK bit.
//
// Optional feature macro: PS2_TX_RETRY_EN
//   defined   : NACK or timeout re-sends the same byte up to RETRY_MAX times
//               before tx_err is pulsed.
//   undefined : the first NACK or timeout pulses tx_err.
//
// Ports
//   clk         in   system clock (50 MHz)
//   reset       in   synchronous, active-high
//   tx_data     in   [7:0] command byte
//   tx_valid    in   request to send tx_data
//   tx_ready    out  idle and able to accept a byte
//   tx_done     out  1-cycle pulse: frame acknowledged by the device
//   tx_err      out  1-cycle pulse: final NACK or timeout
//   busy        out  a frame is in progress
//   rx_inhibit  out  equal to busy; the scan-code receiver drops partial frames
//   ps2_clk_in  in   PS2_CLK pad input (asynchronous)
//   ps2_dat_in  in   PS2_DAT pad input (asynchronous)
//   ps2_clk_oe  out  1 = pull PS2_CLK low, 0 = release
//   ps2_dat_oe  out  1 = pull PS2_DAT low, 0 = release
// ---------------------------------------------------------------------------
module ps2_host_tx #(
  parameter int unsigned INHIBIT_CYC = 6000,
  parameter int unsigned TIMEOUT_CYC = 750000,
  parameter int unsigned FILT_CYC    = 8,
  parameter int unsigned RETRY_MAX   = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_err,
  output logic       busy,
  output logic       rx_inhibit,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe
);

  localparam int unsigned INH_W = $clog2(INHIBIT_CYC + 1);
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);
  localparam int unsigned FLT_W = $clog2(FILT_CYC + 1);
  localparam int unsigned RTY_W = $clog2(RETRY_MAX + 2);

`ifdef PS2_TX_RETRY_EN
  localparam bit RETRY_EN = 1'b1;
`else
  localparam bit RETRY_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_REQ,
    S_BITS,
    S_ACK,
    S_WAITIDLE
  } state_t;

  state_t           r_state;
  logic             r_tx_ready;
  logic             r_tx_done;
  logic             r_tx_err;
  logic             r_busy;
  logic             r_clk_oe;
  logic             r_dat_oe;
  logic [8:0]       r_frame;     // {parity, data}
  logic [3:0]       r_nbit;
  logic [INH_W-1:0] r_icnt;
  logic [TMO_W-1:0] r_tmr;
  logic             r_nack;
  logic [RTY_W-1:0] r_retry;

  logic             r_clk_s1, r_clk_s2;
  logic             r_dat_s1, r_dat_s2;
  logic             r_filt;
  logic [FLT_W-1:0] r_fcnt;
  logic             r_fe;

  logic w_active;
  logic w_timeout;
  logic w_bus_idle;
  logic w_nack_done;
  logic w_fail;
  logic w_can_retry;

  // Two-stage synchroniser plus glitch filter; r_fe pulses once per accepted fall.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_clk_s1 <= 1'b1;
      r_clk_s2 <= 1'b1;
      r_dat_s1 <= 1'b1;
      r_dat_s2 <= 1'b1;
      r_filt   <= 1'b1;
      r_fcnt   <= '0;
      r_fe     <= 1'b0;
    end else begin
      r_clk_s1 <= ps2_clk_in;
      r_clk_s2 <= r_clk_s1;
      r_dat_s1 <= ps2_dat_in;
      r_dat_s2 <= r_dat_s1;
      r_fe     <= 1'b0;
      // Filtered level only follows after FILT_CYC consecutive differing samples.
      if (r_clk_s2 == r_filt) begin
        r_fcnt <= '0;
      end else if (r_fcnt == FLT_W'(FILT_CYC - 1)) begin
        r_filt <= r_clk_s2;
        r_fcnt <= '0;
        r_fe   <= ~r_clk_s2;
      end else begin
        r_fcnt <= r_fcnt + 1'b1;
      end
    end
  end

  assign w_active    = (r_state == S_REQ) || (r_state == S_BITS) ||
                       (r_state == S_ACK) || (r_state == S_WAITIDLE);
  assign w_timeout   = w_active && (r_tmr == TMO_W'(TIMEOUT_CYC - 1));
  assign w_bus_idle  = r_clk_s2 & r_dat_s2;
  assign w_nack_done = (r_state == S_WAITIDLE) && w_bus_idle && r_nack;
  assign w_fail      = w_timeout || w_nack_done;
  assign w_can_retry = RETRY_EN && (r_retry < RTY_W'(RETRY_MAX));

  // Frame sequencer with registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_tx_ready <= 1'b0;
      r_tx_done  <= 1'b0;
      r_tx_err   <= 1'b0;
      r_busy     <= 1'b0;
      r_clk_oe   <= 1'b0;
      r_dat_oe   <= 1'b0;
      r_frame    <= '0;
      r_nbit     <= '0;
      r_icnt     <= '0;
      r_tmr      <= '0;
      r_nack     <= 1'b0;
      r_retry    <= '0;
    end else begin
      r_tx_done <= 1'b0;
      r_tx_err  <= 1'b0;
      if (w_fail) begin
        // Failure: release the bus, then either re-send or report.
        r_dat_oe <= 1'b0;
        if (w_can_retry) begin
          r_retry  <= r_retry + 1'b1;
          r_clk_oe <= 1'b1;
          r_icnt   <= '0;
          r_state  <= S_INHIBIT;
        end else begin
          r_clk_oe <= 1'b0;
          r_tx_err <= 1'b1;
          r_busy   <= 1'b0;
          r_state  <= S_IDLE;
        end
      end else begin
        case (r_state)
          S_IDLE: begin
            r_clk_oe <= 1'b0;
            r_dat_oe <= 1'b0;
            if (r_tx_ready && tx_valid) begin
              r_frame    <= {~^tx_data, tx_data};
              r_retry    <= '0;
              r_tx_ready <= 1'b0;
              r_busy     <= 1'b1;
              r_clk_oe   <= 1'b1;
              r_icnt     <= '0;
              r_state    <= S_INHIBIT;
            end else begin
              r_tx_ready <= 1'b1;
            end
          end
          S_INHIBIT: begin
            r_icnt <= r_icnt + 1'b1;
            // Start bit goes out in the last inhibit cycle.
            if (r_icnt == INH_W'(INHIBIT_CYC - 2)) begin
              r_dat_oe <= 1'b1;
            end
            if (r_icnt == INH_W'(INHIBIT_CYC - 1)) begin
              r_clk_oe <= 1'b0;
              r_tmr    <= '0;
              r_state  <= S_REQ;
            end
          end
          S_REQ: begin
            r_tmr <= r_tmr + 1'b1;
            if (r_fe) begin
              r_dat_oe <= ~r_frame[0];
              r_nbit   <= 4'd1;
              r_state  <= S_BITS;
            end
          end
          S_BITS: begin
            r_tmr <= r_tmr + 1'b1;
            if (r_fe) begin
              if (r_nbit == 4'd9) begin
                r_dat_oe <= 1'b0;  // stop bit
                r_state  <= S_ACK;
              end else begin
                r_dat_oe <= ~r_frame[r_nbit];
                r_nbit   <= r_nbit + 4'd1;
              end
            end
          end
          S_ACK: begin
            r_tmr <= r_tmr + 1'b1;
            if (r_fe) begin
              r_nack  <= r_dat_s2;
              r_state <= S_WAITIDLE;
            end
          end
          S_WAITIDLE: begin
            r_tmr <= r_tmr + 1'b1;
            // NACK completion is taken by the failure branch above.
            if (w_bus_idle) begin
              r_tx_done <= 1'b1;
              r_busy    <= 1'b0;
              r_state   <= S_IDLE;
            end
          end
          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign tx_ready   = r_tx_ready;
  assign tx_done    = r_tx_done;
  assign tx_err     = r_tx_err;
  assign busy       = r_busy;
  assign rx_inhibit = r_busy;
  assign ps2_clk_oe = r_clk_oe;
  assign ps2_dat_oe = r_dat_oe;

endmodule

// File: tb/tb_ps2_host_tx.sv
// ---------------------------------------------------------------------------
// tb_ps2_host_tx
// Bench for ps2_host_tx: a keyboard model that clocks frames at a 40-cycle
// period, samples the host bits and answers ACK/NACK, plus a per-cycle
// monitor of the host outputs and a frame model built from the byte value.
// ---------------------------------------------------------------------------
module tb_ps2_host_tx;

  localparam int unsigned INH  = 20;
  localparam int unsigned TMO  = 4000;
  localparam int unsigned FILT = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, tx_done, tx_err, busy, rx_inhibit;
  logic       ps2_clk_in, ps2_dat_in, ps2_clk_oe, ps2_dat_oe;

  logic dev_clk_low = 1'b0;
  logic dev_dat_low = 1'b0;
  logic glitch = 1'b0;

  // Open-drain bus: low if anyone pulls it.
  assign ps2_clk_in = ~(ps2_clk_oe | dev_clk_low | glitch);
  assign ps2_dat_in = ~(ps2_dat_oe | dev_dat_low);

  ps2_host_tx #(
    .INHIBIT_CYC(INH),
    .TIMEOUT_CYC(TMO),
    .FILT_CYC   (FILT),
    .RETRY_MAX  (2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .tx_done   (tx_done),
    .tx_err    (tx_err),
    .busy      (busy),
    .rx_inhibit(rx_inhibit),
    .ps2_clk_in(ps2_clk_in),
    .ps2_dat_in(ps2_dat_in),
    .ps2_clk_oe(ps2_clk_oe),
    .ps2_dat_oe(ps2_dat_oe)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int n_done = 0;
  int n_errp = 0;
  int n_req = 0;
  int req_cyc = 0;
  int last_err_gap = -1;
  int inh_run = 0;
  logic prev_done = 1'b0;
  logic prev_err = 1'b0;
  logic prev_clk_oe = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Expected line levels of one frame: start, data LSB first, odd parity, stop.
  function automatic logic [10:0] frame_of(input logic [7:0] d);
    logic par;
    par = ($countones(d) % 2 == 0) ? 1'b1 : 1'b0;
    return {1'b1, par, d, 1'b0};
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Per-cycle monitor of host outputs.
  always @(negedge clk) begin
    if (!reset) begin
      check("rx_inhibit_eq_busy", rx_inhibit, busy);
      check("done_err_exclusive", tx_done & tx_err, 0);
      if (tx_ready) check("ready_implies_idle", busy, 0);
      if (!busy) check("idle_lines_released", {ps2_clk_oe, ps2_dat_oe}, 0);
      if (tx_done) begin
        check("done_one_cycle", prev_done, 0);
        n_done++;
      end
      if (tx_err) begin
        check("err_one_cycle", prev_err, 0);
        n_errp++;
        last_err_gap = cyc - req_cyc;
      end
      if (ps2_clk_oe) begin
        if (ps2_dat_oe) check("start_in_last_inhibit", inh_run, INH - 1);
        inh_run++;
      end else if (inh_run != 0) begin
        check("inhibit_len", inh_run, INH);
        inh_run = 0;
      end
      if (prev_clk_oe && !ps2_clk_oe && ps2_dat_oe) begin
        n_req++;
        req_cyc = cyc;
      end
    end
    prev_done   = tx_done;
    prev_err    = tx_err;
    prev_clk_oe = ps2_clk_oe;
  end

  task automatic start(input logic [7:0] d);
    int i;
    i = 0;
    while (!tx_ready && i < 500) begin
      @(negedge clk);
      i++;
    end
    check("ready_before_send", tx_ready, 1);
    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int i;
    i = 0;
    while (busy && i < 1000) begin
      @(negedge clk);
      i++;
    end
    check("return_to_idle", busy, 0);
    repeat (3) @(negedge clk);
  endtask

  // Keyboard model: clocks 11 pulses, samples host bits before each rise.
  task automatic dev_frame(input bit ack, input int rst_k, input int glitch_k,
                           input bit hold, output logic [10:0] bits);
    int i;
    bits = '0;
    i = 0;
    while (!(busy && !ps2_clk_oe && ps2_dat_oe) && i < 2000) begin
      @(negedge clk);
      i++;
    end
    check("dev_saw_request", busy && !ps2_clk_oe && ps2_dat_oe, 1);
    repeat (20) @(negedge clk);
    bits[0] = ps2_dat_in;
    for (int k = 1; k <= 11; k++) begin
      if (k == 11 && ack) dev_dat_low = 1'b1;
      dev_clk_low = 1'b1;
      if (hold && k == 2) begin
        tx_data  = 8'h55;
        tx_valid = 1'b1;
      end
      if (hold && k == 8) tx_valid = 1'b0;
      if (k == rst_k) begin
        repeat (8) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("rst_mid_oe", {ps2_clk_oe, ps2_dat_oe}, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_ready", tx_ready, 0);
        check("rst_mid_done_err", {tx_done, tx_err}, 0);
        reset = 1'b0;
        dev_clk_low = 1'b0;
        dev_dat_low = 1'b0;
        return;
      end
      repeat (20) @(negedge clk);
      if (k <= 10) bits[k] = ps2_dat_in;
      dev_clk_low = 1'b0;
      dev_dat_low = 1'b0;
      if (k == glitch_k) begin
        repeat (8) @(negedge clk);
        glitch = 1'b1;
        @(negedge clk);
        glitch = 1'b0;
        repeat (11) @(negedge clk);
      end else begin
        repeat (20) @(negedge clk);
      end
    end
  endtask

  // One ACKed frame checked against the frame model.
  task automatic run_ack(input logic [7:0] d, input int glitch_k, input bit hold,
                         output logic [10:0] bits);
    int d0, e0, r0;
    d0 = n_done;
    e0 = n_errp;
    r0 = n_req;
    start(d);
    dev_frame(1'b1, 0, glitch_k, hold, bits);
    wait_idle();
    check("frame_bits", bits, frame_of(d));
    check("ack_done_count", n_done - d0, 1);
    check("ack_err_count", n_errp - e0, 0);
    check("ack_req_count", n_req - r0, 1);
  endtask

  initial begin
    logic [10:0] bits;
    int d0, e0, r0, i;

    // Reset state.
    repeat (4) @(negedge clk);
    check("reset_oe", {ps2_clk_oe, ps2_dat_oe}, 0);
    check("reset_ready", tx_ready, 0);
    check("reset_busy", {busy, rx_inhibit}, 0);
    check("reset_done_err", {tx_done, tx_err}, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("ready_after_reset", tx_ready, 1);

    // 0xED, ACK.
    run_ack(8'hED, 0, 1'b0, bits);
    check("ed_literal", bits, 11'h7DA);

    // Parity corners.
    run_ack(8'h00, 0, 1'b0, bits);
    check("00_literal", bits, 11'h600);
    run_ack(8'hFF, 0, 1'b0, bits);
    check("ff_literal", bits, 11'h7FE);
    run_ack(8'h01, 0, 1'b0, bits);
    check("01_literal", bits, 11'h402);

    // Device never clocks: timeout.
    d0 = n_done;
    e0 = n_errp;
    r0 = n_req;
    start(8'hAB);
    i = 0;
    while (n_errp == e0 && i < 15000) begin
      @(negedge clk);
      i++;
    end
    check("timeout_err_count", n_errp - e0, 1);
    check("timeout_gap", last_err_gap, TMO);
    check("timeout_done_count", n_done - d0, 0);
`ifdef PS2_TX_RETRY_EN
    check("timeout_attempts", n_req - r0, 3);
`else
    check("timeout_attempts", n_req - r0, 1);
`endif
    repeat (2) @(negedge clk);
    check("timeout_lines", {ps2_clk_oe, ps2_dat_oe}, 0);
    check("timeout_ready", tx_ready, 1);

    // NACK.
    d0 = n_done;
    e0 = n_errp;
    r0 = n_req;
    start(8'hF0);
`ifdef PS2_TX_RETRY_EN
    for (int t = 0; t < 3; t++) dev_frame(1'b0, 0, 0, 1'b0, bits);
`else
    dev_frame(1'b0, 0, 0, 1'b0, bits);
`endif
    wait_idle();
    check("nack_bits", bits, frame_of(8'hF0));
    check("nack_err_count", n_errp - e0, 1);
    check("nack_done_count", n_done - d0, 0);
`ifdef PS2_TX_RETRY_EN
    check("nack_attempts", n_req - r0, 3);
    // ACK on the second attempt.
    d0 = n_done;
    e0 = n_errp;
    r0 = n_req;
    start(8'h12);
    dev_frame(1'b0, 0, 0, 1'b0, bits);
    dev_frame(1'b1, 0, 0, 1'b0, bits);
    wait_idle();
    check("retry_bits", bits, frame_of(8'h12));
    check("retry_done_count", n_done - d0, 1);
    check("retry_err_count", n_errp - e0, 0);
    check("retry_attempts", n_req - r0, 2);
`else
    check("nack_attempts", n_req - r0, 1);
`endif

    // Reset at fe#5, then a clean 0xF4.
    d0 = n_done;
    e0 = n_errp;
    start(8'h3C);
    dev_frame(1'b1, 5, 0, 1'b0, bits);
    repeat (60) @(negedge clk);
    check("rst_abort_no_pulse", (n_done - d0) + (n_errp - e0), 0);
    run_ack(8'hF4, 0, 1'b0, bits);

    // Clock glitch in BITS and tx_valid held while busy.
    r0 = n_req;
    run_ack(8'hA5, 3, 1'b1, bits);
    repeat (60) @(negedge clk);
    check("held_valid_ignored", n_req - r0, 1);
    check("held_valid_idle", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, %0d compared", n_cmp);
    $fatal(1);
  end

endmodule
